// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt source and request block: owns Cause.IP/TI, Count and Compare,
// and raises a registered interrupt request to the exception-commit stage.
module cp0_int_ctrl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] status_data,
    input  logic [5:0]  ext_int,
    input  logic        mtc0_we,
    input  logic [5:0]  cp0_addr,
    input  logic [31:0] mtc0_data,
    input  logic        exception,
    output logic [7:0]  cause_ip,
    output logic        cause_ti,
    output logic [31:0] count_data,
    output logic [31:0] compare_data,
    output logic        int_req
);

    localparam int unsigned HW_W = 6;
    localparam logic [5:0] ADDR_COUNT   = 6'd9;
    localparam logic [5:0] ADDR_COMPARE = 6'd11;
    localparam logic [5:0] ADDR_CAUSE   = 6'd13;

    logic [SYNC_STAGES-1:0][HW_W-1:0] sync_q;
    logic [HW_W-1:0] hw_s;
    logic [1:0]      ip_sw_q, ip_sw_d;
    logic            tick_q, tick_d;
    logic            ti_q, ti_d;
    logic [31:0]     count_q, count_d;
    logic [31:0]     compare_q, compare_d;
    logic            int_req_q, int_req_d;
    logic [31:0]     count_inc;
    logic            wr_count, wr_compare, wr_cause;
    logic            unused_bits;

    assign hw_s       = sync_q[SYNC_STAGES-1];
    assign wr_count   = mtc0_we && (cp0_addr == ADDR_COUNT);
    assign wr_compare = mtc0_we && (cp0_addr == ADDR_COMPARE);
    assign wr_cause   = mtc0_we && (cp0_addr == ADDR_CAUSE);

    // Hardware IP bits are live levels; the timer shares IP7 with HW5.
    assign cause_ip     = {hw_s[5] | ti_q, hw_s[4:0], ip_sw_q};
    assign cause_ti     = ti_q;
    assign count_data   = count_q;
    assign compare_data = compare_q;
    assign int_req      = int_req_q;

    assign unused_bits = ^{status_data[31:16], status_data[7:2]};

    always_comb begin
        count_inc = count_q + 32'd1;
        tick_d    = ~tick_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        ip_sw_d   = ip_sw_q;

        // A Count write restarts the half-rate phase so the value holds two cycles.
        if (wr_count) begin
            count_d = mtc0_data;
            tick_d  = 1'b0;
        end else if (tick_q) begin
            count_d = count_inc;
            if (count_inc == compare_q) begin
                ti_d = 1'b1;
            end
        end

        if (wr_compare) begin
            compare_d = mtc0_data;
            ti_d      = 1'b0;
        end

        if (wr_cause) begin
            ip_sw_d = mtc0_data[9:8];
        end

        int_req_d = (|(cause_ip & status_data[15:8])) & status_data[0]
                    & ~status_data[1] & ~exception;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            ip_sw_q   <= 2'b00;
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            int_req_q <= 1'b0;
        end else begin
            sync_q    <= (SYNC_STAGES*HW_W)'({sync_q, ext_int});
            ip_sw_q   <= ip_sw_d;
            tick_q    <= tick_d;
            ti_q      <= ti_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            int_req_q <= int_req_d;
        end
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Scoreboarded bench for cp0_int_ctrl: directed test-plan scenarios plus a
// randomized phase, checked against a cycle-level behavioural model.
module tb_cp0_int_ctrl;

    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] status_data;
    logic [5:0]  ext_int;
    logic        mtc0_we;
    logic [5:0]  cp0_addr;
    logic [31:0] mtc0_data;
    logic        exception;
    logic [7:0]  cause_ip;
    logic        cause_ti;
    logic [31:0] count_data;
    logic [31:0] compare_data;
    logic        int_req;

    cp0_int_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .status_data(status_data), .ext_int(ext_int),
        .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .mtc0_data(mtc0_data),
        .exception(exception), .cause_ip(cause_ip), .cause_ti(cause_ti),
        .count_data(count_data), .compare_data(compare_data), .int_req(int_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ip;
        logic        ti;
        logic [31:0] cnt;
        logic [31:0] cmp;
        logic        req;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   mon_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: Count = last loaded value + half the edges since the load.
    logic [5:0]  hist [0:2];
    logic [31:0] m_base, m_cmp, c_old, c_new;
    int          m_k;
    logic        m_ti, m_req, m_pend;
    logic [1:0]  m_sw;
    logic [7:0]  ip_old;
    exp_t        e_new;

    function automatic logic [7:0] model_ip();
        logic [5:0] hw;
        hw = hist[SYNC-1];
        return {hw[5] | m_ti, hw[4:0], m_sw};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) hist[i] = 6'd0;
            m_base = 32'd0; m_k = 0; m_cmp = 32'd0;
            m_ti = 1'b0; m_sw = 2'b00; m_req = 1'b0;
            exp_q.delete();
        end else begin
            ip_old = model_ip();
            c_old  = m_base + 32'(m_k / 2);
            m_pend = |(ip_old & status_data[15:8]);
            m_req  = m_pend && status_data[0] && !status_data[1] && !exception;
            for (int i = 2; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = ext_int;
            if (mtc0_we && cp0_addr == 6'd9) begin
                m_base = mtc0_data;
                m_k    = 0;
            end else begin
                m_k++;
            end
            c_new = m_base + 32'(m_k / 2);
            if (mtc0_we && cp0_addr == 6'd11) begin
                m_cmp = mtc0_data;
                m_ti  = 1'b0;
            end else if (!(mtc0_we && cp0_addr == 6'd9) && c_new != c_old && c_new == m_cmp) begin
                m_ti = 1'b1;
            end
            if (mtc0_we && cp0_addr == 6'd13) m_sw = mtc0_data[9:8];
            e_new = '{ip: model_ip(), ti: m_ti, cnt: c_new, cmp: m_cmp, req: m_req};
            exp_q.push_back(e_new);
        end
    end

    // Monitor: the block presents its full state every cycle.
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            mon_cnt++;
            check("mon_cause_ip", 32'(cause_ip), 32'(e.ip));
            check("mon_cause_ti", 32'(cause_ti), 32'(e.ti));
            check("mon_count", count_data, e.cnt);
            check("mon_compare", compare_data, e.cmp);
            check("mon_int_req", 32'(int_req), 32'(e.req));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mtc0(input logic [5:0] addr, input logic [31:0] data);
        mtc0_we = 1'b1; cp0_addr = addr; mtc0_data = data;
        step(1);
        mtc0_we = 1'b0; cp0_addr = 6'd0; mtc0_data = 32'd0;
    endtask

    task automatic check_count_seq();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_cnt0", count_data, 32'd0);
        step(1); check("rel_cnt1", count_data, 32'd0);
        step(1); check("rel_cnt2", count_data, 32'd1);
        step(1); check("rel_cnt3", count_data, 32'd1);
        step(1); check("rel_cnt4", count_data, 32'd2);
    endtask

    logic [31:0] mask_st [0:2];

    initial begin
        rst_n = 1'b0; status_data = 32'd0; ext_int = 6'd0; mtc0_we = 1'b0;
        cp0_addr = 6'd0; mtc0_data = 32'd0; exception = 1'b0;
        step(2);
        check("rst_ip", 32'(cause_ip), 32'd0);
        check("rst_req", 32'(int_req), 32'd0);
        check("rst_cmp", compare_data, 32'd0);
        check_count_seq();

        // Hardware interrupt latency, rise and fall.
        status_data = 32'h0000_0401; ext_int = 6'h01;
        step(1); check("hw_ip_early", 32'(cause_ip), 32'h00);
        step(1); check("hw_ip_set", 32'(cause_ip), 32'h04);
        check("hw_req_early", 32'(int_req), 32'd0);
        step(1); check("hw_req_set", 32'(int_req), 32'd1);
        ext_int = 6'h00;
        step(2); check("hw_ip_clr", 32'(cause_ip), 32'h00);
        check("hw_req_hold", 32'(int_req), 32'd1);
        step(1); check("hw_req_clr", 32'(int_req), 32'd0);

        // Masking by EXL, IE and IM2.
        mask_st[0] = 32'h0000_0403; mask_st[1] = 32'h0000_0400; mask_st[2] = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            status_data = mask_st[i]; ext_int = 6'h01;
            step(3);
            check("mask_ip", 32'(cause_ip), 32'h04);
            check("mask_req", 32'(int_req), 32'd0);
            ext_int = 6'h00;
            step(3);
        end

        // Exception suppresses the request for its cycle.
        status_data = 32'h0000_0400; ext_int = 6'h01;
        step(2);
        status_data = 32'h0000_0401; exception = 1'b1;
        step(1); check("exc_req_supp", 32'(int_req), 32'd0);
        exception = 1'b0;
        step(1); check("exc_req_after", 32'(int_req), 32'd1);
        ext_int = 6'h00; status_data = 32'd0;
        step(3);

        // Timer interrupt.
        status_data = 32'h0000_8001;
        mtc0(6'd11, 32'd10);
        mtc0(6'd9, 32'd8);
        check("tmr_cnt_load", count_data, 32'd8);
        step(3); check("tmr_cnt9", count_data, 32'd9);
        check("tmr_ti_early", 32'(cause_ti), 32'd0);
        step(1); check("tmr_cnt10", count_data, 32'd10);
        check("tmr_ti_set", 32'(cause_ti), 32'd1);
        check("tmr_ip7", 32'(cause_ip), 32'h80);
        check("tmr_req_early", 32'(int_req), 32'd0);
        step(1); check("tmr_req_set", 32'(int_req), 32'd1);
        mtc0(6'd11, 32'd100);
        check("tmr_ti_clr", 32'(cause_ti), 32'd0);
        step(1); check("tmr_req_clr", 32'(int_req), 32'd0);

        // Count wrap and equal-value write.
        status_data = 32'd0;
        mtc0(6'd11, 32'd0);
        mtc0(6'd9, 32'hFFFF_FFFF);
        check("wrap_load", count_data, 32'hFFFF_FFFF);
        step(2); check("wrap_cnt", count_data, 32'd0);
        check("wrap_ti", 32'(cause_ti), 32'd1);
        mtc0(6'd11, 32'd50);
        mtc0(6'd9, 32'd50);
        check("eq_ti0", 32'(cause_ti), 32'd0);
        step(1); check("eq_ti1", 32'(cause_ti), 32'd0);

        // Software interrupt.
        status_data = 32'h0000_0201;
        mtc0(6'd13, 32'h0000_0200);
        check("sw_ip_set", 32'(cause_ip), 32'h02);
        check("sw_req_early", 32'(int_req), 32'd0);
        step(1); check("sw_req_set", 32'(int_req), 32'd1);
        mtc0(6'd13, 32'd0);
        check("sw_ip_clr", 32'(cause_ip), 32'h00);
        step(1); check("sw_req_clr", 32'(int_req), 32'd0);

        // Asynchronous reset mid-count with all lines high.
        status_data = 32'h0000_FF01; ext_int = 6'h3F;
        step(5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ip", 32'(cause_ip), 32'd0);
        check("arst_ti", 32'(cause_ti), 32'd0);
        check("arst_cnt", count_data, 32'd0);
        check("arst_cmp", compare_data, 32'd0);
        check("arst_req", 32'(int_req), 32'd0);
        ext_int = 6'h00; status_data = 32'd0;
        check_count_seq();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) ext_int = 6'($urandom);
            if ($urandom_range(0, 5) == 0) status_data = $urandom & 32'h0000_FF03;
            exception = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                mtc0_we = 1'b1;
                case ($urandom_range(0, 3))
                    0: begin cp0_addr = 6'd9;  mtc0_data = $urandom_range(0, 40); end
                    1: begin cp0_addr = 6'd11; mtc0_data = $urandom_range(0, 40); end
                    2: begin cp0_addr = 6'd13; mtc0_data = $urandom; end
                    default: begin cp0_addr = 6'd12; mtc0_data = $urandom; end
                endcase
            end else begin
                mtc0_we = 1'b0;
            end
            step(1);
        end
        mtc0_we = 1'b0; exception = 1'b0; ext_int = 6'd0;
        step(4);
        @(negedge clk);
        #1 check("mon_active", 32'(mon_cnt > 500), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
